maxnet_engine: RTL

Self-contained 4-neuron MaxNet winner-take-all engine, the consumer/controller side of the Actel-cell MaxNet datapath. It accepts a 4-value vector through a valid/ready handshake. It then iterates lateral inhibition, one update per clock, until at most one neuron stays nonzero or an iteration cap is reached. It returns the winner index and value through a second valid/ready handshake.

---
 rtl/maxnet_pkg.sv | 18 +
 rtl/maxnet_neuron.sv | 32 +++
 rtl/maxnet_engine.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the MaxNet winner-take-all engine.
package maxnet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NEURONS = 4;
    localparam int IDX_W   = 2;

    // The signed difference needs headroom for the W+2 bit sum plus a sign bit.
    function automatic int clamp_sub_width(input int w);
        return w + 3;
    endfunction

endpackage

// File: rtl/maxnet_neuron.sv
// One MaxNet neuron: self value minus epsilon-weighted sum of the others,
// clamped at zero.
module maxnet_neuron
    import maxnet_pkg::*;
#(
    parameter int W         = 8,
    parameter int EPS_SHIFT = 3
) (
    input  logic [W-1:0] x_self_i,
    input  logic [W+1:0] sum_i,
    output logic [W-1:0] x_next_o
);

    localparam int DW = clamp_sub_width(W);

    logic [W+1:0]  others_s;
    logic [DW-1:0] inhib_s;
    logic [DW-1:0] diff_s;

    // Lateral inhibition update with negative results clamped to zero
    always_comb begin
        others_s = sum_i - {2'b00, x_self_i};
        inhib_s  = DW'(others_s >> EPS_SHIFT);
        diff_s   = DW'(x_self_i) - inhib_s;
        if (diff_s[DW-1]) begin
            x_next_o = '0;
        end else begin
            x_next_o = diff_s[W-1:0];
        end
    end

endmodule

// File: rtl/maxnet_engine.sv
// 4-neuron MaxNet engine: accept a vector, iterate inhibition one update per
// clock until at most one neuron survives or the cap hits, then report argmax.
module maxnet_engine
    import maxnet_pkg::*;
#(
    parameter int W         = 8,
    parameter int EPS_SHIFT = 3,
    parameter int MAX_ITER  = 31
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*W-1:0]     in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic [W-1:0]       out_value,
    output logic               out_timeout
);

    localparam int IW = $clog2(MAX_ITER + 1);

    state_e             state_q, state_d;
    logic [W-1:0]       x_q     [NEURONS];
    logic [W-1:0]       x_d     [NEURONS];
    logic [W-1:0]       x_upd_s [NEURONS];
    logic [IW-1:0]      iter_q, iter_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   out_index_q, out_index_d;
    logic [W-1:0]       out_value_q, out_value_d;
    logic               out_timeout_q, out_timeout_d;

    logic [W+1:0]       sum_s;
    logic [2:0]         nz_cnt_s;
    logic [IDX_W-1:0]   max_idx_s;
    logic [W-1:0]       max_val_s;

    for (genvar g = 0; g < NEURONS; g++) begin : g_neuron
        maxnet_neuron #(
            .W         (W),
            .EPS_SHIFT (EPS_SHIFT)
        ) u_neuron (
            .x_self_i (x_q[g]),
            .sum_i    (sum_s),
            .x_next_o (x_upd_s[g])
        );
    end

    // Sum, survivor count and lowest-index argmax over the current values
    always_comb begin
        sum_s     = '0;
        nz_cnt_s  = '0;
        max_idx_s = '0;
        max_val_s = '0;
        for (int i = 0; i < NEURONS; i++) begin
            sum_s = sum_s + (W+2)'(x_q[i]);
            if (x_q[i] != '0) begin
                nz_cnt_s = nz_cnt_s + 3'd1;
            end else begin
                nz_cnt_s = nz_cnt_s;
            end
            // Strict compare keeps the lowest index on ties
            if (x_q[i] > max_val_s) begin
                max_val_s = x_q[i];
                max_idx_s = IDX_W'(i);
            end else begin
                max_val_s = max_val_s;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        iter_d        = iter_q;
        x_d           = x_q;
        out_valid_d   = out_valid_q;
        out_index_d   = out_index_q;
        out_value_d   = out_value_q;
        out_timeout_d = out_timeout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ITER;
                    iter_d  = '0;
                    for (int i = 0; i < NEURONS; i++) begin
                        x_d[i] = in_data[i*W +: W];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                if (nz_cnt_s <= 3'd1) begin
                    state_d       = DONE;
                    out_valid_d   = 1'b1;
                    out_index_d   = max_idx_s;
                    out_value_d   = max_val_s;
                    out_timeout_d = 1'b0;
                end else if (iter_q == IW'(MAX_ITER)) begin
                    state_d       = DONE;
                    out_valid_d   = 1'b1;
                    out_index_d   = max_idx_s;
                    out_value_d   = max_val_s;
                    out_timeout_d = 1'b1;
                end else begin
                    x_d    = x_upd_s;
                    iter_d = iter_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q       <= IDLE;
            iter_q        <= '0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            out_value_q   <= '0;
            out_timeout_q <= 1'b0;
            for (int i = 0; i < NEURONS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            iter_q        <= iter_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            out_value_q   <= out_value_d;
            out_timeout_q <= out_timeout_d;
            for (int i = 0; i < NEURONS; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign out_value   = out_value_q;
    assign out_timeout = out_timeout_q;

endmodule
